// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO engine for MULT, MULTU, DIV and DIVU.
// Iterative radix-2 datapath: shift-add multiply and restoring divide,
// one step per cycle, followed by a sign-fixup cycle that writes hi/lo.
// Optional macro MDU_FAST_MUL_EN: multiplies complete through a single-cycle
// 2*WIDTH multiplier; divides keep the iterative path.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     counter;
    logic                 accept;
    logic                 fast_mul;
    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    // operation context captured at start
    logic                 is_div, neg_q, neg_r, div_zero;
    logic [WIDTH-1:0]     a_raw;
    // iterative datapath state
    logic [2*WIDTH-1:0]   mcand, prod;
    logic [WIDTH-1:0]     opb, quot, rem;
    logic [WIDTH:0]       partial, trial;
    logic [WIDTH-1:0]     res_hi, res_lo;

    function automatic logic [WIDTH-1:0] fix_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] fix_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

`ifdef MDU_FAST_MUL_EN
    assign fast_mul = ~op[1];
`else
    assign fast_mul = 1'b0;
`endif

    assign accept = (state == IDLE) && start && !flush;
    assign busy   = (state != IDLE);

    // Signed ops (op[0]==0) work on magnitudes; 0x8000_0000 maps to itself,
    // which is the correct unsigned magnitude.
    assign sign_a = ~op[0] & a[WIDTH-1];
    assign sign_b = ~op[0] & b[WIDTH-1];
    assign mag_a  = fix_w(a, sign_a);
    assign mag_b  = fix_w(b, sign_b);

    // Restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor; a borrow in the top bit means restore.
    assign partial = {rem, quot[WIDTH-1]};
    assign trial   = partial - {1'b0, opb};

    // Result after sign fixup, written to hi/lo in FIX
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        if (!is_div) begin
            {res_hi, res_lo} = fix_2w(prod, neg_q);
        end else if (div_zero) begin
            res_hi = a_raw;
            res_lo = '1;
        end else begin
            res_hi = fix_w(rem, neg_r);
            res_lo = fix_w(quot, neg_q);
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = fast_mul ? FIX : RUN;
            RUN:     if (counter == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Control state, iteration counter, result registers and done pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            counter <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            counter <= (state == RUN && !flush) ? counter + 1'b1 : '0;
            done    <= 1'b0;
            if (state == FIX && !flush) begin
                hi   <= res_hi;
                lo   <= res_lo;
                done <= 1'b1;
            end
        end
    end

    // Operand capture and one multiply or divide iteration per RUN cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div   <= op[1];
            a_raw    <= a;
            div_zero <= (b == '0);
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
            mcand    <= {{WIDTH{1'b0}}, mag_a};
            opb      <= mag_b;
            rem      <= '0;
            quot     <= mag_a;
            prod     <= fast_mul ? ({{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b}) : '0;
        end else if (state == RUN) begin
            if (!is_div) begin
                if (opb[0]) prod <= prod + mcand;
                mcand <= mcand << 1;
                opb   <= opb >> 1;
            end else if (!trial[WIDTH]) begin
                rem  <= trial[WIDTH-1:0];
                quot <= {quot[WIDTH-2:0], 1'b1};
            end else begin
                rem  <= partial[WIDTH-1:0];
                quot <= {quot[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule
